// File: rtl/video_pkg.sv
// video_pkg: shared YCbCr types, pattern selects, 75% bar colours, blanking and fvht bit constants
package video_pkg;
  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;
  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_FLAT  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_BLACK = 2'd3
  } pat_e;
  localparam logic [9:0] Y_BLANK = 10'h040;
  localparam logic [9:0] C_BLANK = 10'h200;
  localparam logic [9:0] Y_RAMP_MAX = 10'd940;
  localparam int F = 3;
  localparam int V = 2;
  localparam int H = 1;
  localparam int T = 0;
  localparam logic [3:0] FVHT_IDLE = 4'b0110;
  localparam ycbcr_t BLACK = '{Y_BLANK, C_BLANK, C_BLANK};
  localparam ycbcr_t BARS [8] = '{
    '{10'd721, 10'd512, 10'd512},
    '{10'd646, 10'd176, 10'd567},
    '{10'd525, 10'd625, 10'd176},
    '{10'd450, 10'd289, 10'd231},
    '{10'd335, 10'd735, 10'd793},
    '{10'd260, 10'd399, 10'd848},
    '{10'd139, 10'd848, 10'd457},
    '{10'd64,  10'd512, 10'd512}
  };
endpackage

// File: rtl/video_raster_cnt.sv
// video_raster_cnt: h/v/frame counters with registered fvht decode; sof/act describe the current counter sample
module video_raster_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_BLANK = 280,
  parameter int V_ACTIVE = 1080,
  parameter int V_BLANK = 45,
  localparam int H_TOTAL = H_ACTIVE + H_BLANK,
  localparam int V_TOTAL = V_ACTIVE + V_BLANK,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic [3:0]    fvht,
  output logic [15:0]   frame_cnt,
  output logic          sof,
  output logic          act
);
  logic [VW-1:0] v_cnt;
  logic h_wrap, v_wrap;
  logic [3:0] fvht_nxt;
  always_comb begin
    h_wrap = h_cnt == HW'(H_TOTAL - 1);
    v_wrap = v_cnt == VW'(V_TOTAL - 1);
    sof = h_cnt == '0 && v_cnt == '0;
    act = h_cnt >= HW'(H_BLANK) && v_cnt >= VW'(V_BLANK);
    fvht_nxt = '0;
    fvht_nxt[V] = v_cnt < VW'(V_BLANK);
    fvht_nxt[H] = h_cnt < HW'(H_BLANK);
    fvht_nxt[T] = sof;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame_cnt <= '0;
      fvht <= FVHT_IDLE;
    end else if (cen) begin
      if (!en) begin
        h_cnt <= '0;
        v_cnt <= '0;
        fvht <= FVHT_IDLE;
      end else begin
        fvht <= fvht_nxt;
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing (fvht_o) plus frame-latched 4:2:2 test pattern (vdat_o), frame count out, advancing on cen_i
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_BLANK = 280,
  parameter int V_ACTIVE = 1080,
  parameter int V_BLANK = 45
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cen_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [29:0] flat_ycbcr_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] vdat_o,
  output logic [15:0] frame_cnt_o
);
  localparam int HW = $clog2(H_ACTIVE + H_BLANK);
  localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
  logic [HW-1:0] h_cnt, x, bar_cnt;
  logic sof, act;
  pat_e pat;
  ycbcr_t flat, col;
  logic [2:0] bar_idx;
  logic [15:0] ramp_sum;
  logic [9:0] ramp_y, cr_hold, luma, chroma;
  video_raster_cnt #(
    .H_ACTIVE(H_ACTIVE),
    .H_BLANK(H_BLANK),
    .V_ACTIVE(V_ACTIVE),
    .V_BLANK(V_BLANK)
  ) u_raster (
    .clk(clk_i),
    .rstn(rstn_i),
    .cen(cen_i),
    .en(en_i),
    .h_cnt(h_cnt),
    .fvht(fvht_o),
    .frame_cnt(frame_cnt_o),
    .sof(sof),
    .act(act)
  );
  always_comb begin
    x = h_cnt - HW'(H_BLANK);
    ramp_sum = 16'(x >> 1) + 16'd64;
    ramp_y = ramp_sum > 16'(Y_RAMP_MAX) ? Y_RAMP_MAX : ramp_sum[9:0];
    col = pat == PAT_BARS ? BARS[bar_idx] :
          pat == PAT_FLAT ? flat :
          pat == PAT_RAMP ? ycbcr_t'{ramp_y, C_BLANK, C_BLANK} : BLACK;
    luma = act ? col.y : Y_BLANK;
    chroma = act ? (x[0] ? cr_hold : col.cb) : C_BLANK;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pat <= PAT_BLACK;
      flat <= BLACK;
      bar_idx <= '0;
      bar_cnt <= BAR_LAST;
      cr_hold <= C_BLANK;
      vdat_o <= {Y_BLANK, C_BLANK};
    end else if (cen_i) begin
      if (!en_i) begin
        bar_idx <= '0;
        bar_cnt <= BAR_LAST;
        vdat_o <= {Y_BLANK, C_BLANK};
      end else begin
        vdat_o <= {luma, chroma};
        if (sof) begin
          pat <= pat_e'(pat_sel_i);
          flat <= flat_ycbcr_i;
        end
        bar_cnt <= (!act || bar_cnt == '0) ? BAR_LAST : bar_cnt - 1'b1;
        bar_idx <= !act ? '0 : bar_cnt == '0 ? bar_idx + 1'b1 : bar_idx;
        if (act && !x[0]) cr_hold <= col.cr;
      end
    end
  end
endmodule
